// File: rtl/exec_sequencer.sv
// exec_sequencer
// Run-control sequencer between the host-facing logic and the processor core.
// It starts, single-steps and stops program execution by driving the core run
// enable and pc reset. It also counts executed cycles, enforces a watchdog
// limit and can stop on a pc breakpoint.
//
// Optional feature macro: EXEC_SEQUENCER_BREAKPOINT_EN
//   defined   -> pc breakpoint compare is built
//   undefined -> bp_addr_in / bp_valid_in are ignored, bp_hit_out stays 0
//
// Parameters:
//   PC_W      width of the program counter
//   CYC_W     width of the executed-cycle counter
//   WDT_LIMIT watchdog limit in RUN cycles (0 disables), <= 2^CYC_W-1
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_in        run request (sampled in IDLE, wins over step_in)
//   step_in         single-step request (sampled in IDLE)
//   halt_in         abort request (honoured in RUN)
//   pc_in           current core pc
//   pc_en_in        core pc-advance enable; 0 in RUN = program terminated
//   bp_addr_in      breakpoint address
//   bp_valid_in     breakpoint armed
//   core_en_out     core run enable (combinational)
//   core_rst_out    core pc reset, one cycle in ARM
//   busy_out        high in ARM, RUN and STEP
//   done_out        one-cycle pulse in DONE
//   timeout_out     sticky watchdog-expired flag
//   bp_hit_out      sticky stopped-on-breakpoint flag
//   cycles_out      cycles with core_en_out high since last ARM (saturating)

module exec_sequencer #(
   parameter int PC_W      = 4,
   parameter int CYC_W     = 8,
   parameter int WDT_LIMIT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic             step_in,
   input  logic             halt_in,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             pc_en_in,
   input  logic [PC_W-1:0]  bp_addr_in,
   input  logic             bp_valid_in,
   output logic             core_en_out,
   output logic             core_rst_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             timeout_out,
   output logic             bp_hit_out,
   output logic [CYC_W-1:0] cycles_out
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ARM  = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_STEP = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [CYC_W-1:0] CYC_MAX_C = {CYC_W{1'b1}};
   localparam logic [CYC_W:0]   WDT_LIM_C = (CYC_W+1)'(WDT_LIMIT);
   localparam logic             WDT_EN_C  = (WDT_LIMIT != 0);

   logic [2:0]       state_r;
   logic [2:0]       next_state_s;
   logic [CYC_W-1:0] cycles_r;
   logic             timeout_r;
   logic             bp_hit_r;
   logic             core_rst_r;
   logic             busy_r;
   logic             done_r;
   logic             core_en_s;
   logic             bp_match_s;
   logic             wdt_hit_s;
   logic             set_timeout_s;
   logic             set_bp_s;

`ifdef EXEC_SEQUENCER_BREAKPOINT_EN
   // A match right after ARM (count still 0) is suppressed so a run started
   // on the breakpoint address makes progress.
   assign bp_match_s = bp_valid_in & (pc_in == bp_addr_in) & (cycles_r != {CYC_W{1'b0}});
`else
   logic unused_bp_s;
   assign unused_bp_s = ^{bp_addr_in, bp_valid_in};
   assign bp_match_s  = 1'b0;
`endif

   // Watchdog fires on the cycle that would bring the count up to the limit;
   // that cycle is still executed and counted.
   assign wdt_hit_s = WDT_EN_C &
                      (({1'b0, cycles_r} + {{CYC_W{1'b0}}, 1'b1}) == WDT_LIM_C);

   // Next-state decode, core enable and sticky-flag set conditions.
   always_comb begin
      next_state_s  = state_r;
      core_en_s     = 1'b0;
      set_timeout_s = 1'b0;
      set_bp_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_in) begin
               next_state_s = ST_ARM;
            end else if (step_in) begin
               next_state_s = ST_STEP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            next_state_s = ST_RUN;
         end
         ST_RUN: begin
            // Halt and breakpoint gate the enable in the same cycle;
            // terminate and watchdog let the current cycle execute.
            if (halt_in) begin
               next_state_s = ST_DONE;
            end else if (bp_match_s) begin
               set_bp_s     = 1'b1;
               next_state_s = ST_DONE;
            end else if (!pc_en_in) begin
               core_en_s    = 1'b1;
               next_state_s = ST_DONE;
            end else if (wdt_hit_s) begin
               core_en_s     = 1'b1;
               set_timeout_s = 1'b1;
               next_state_s  = ST_DONE;
            end else begin
               core_en_s    = 1'b1;
               next_state_s = ST_RUN;
            end
         end
         ST_STEP: begin
            core_en_s    = 1'b1;
            next_state_s = ST_DONE;
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered status outputs. Counter and flags are
   // cleared on entry to ARM so they already read 0 during the ARM cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cycles_r   <= {CYC_W{1'b0}};
         timeout_r  <= 1'b0;
         bp_hit_r   <= 1'b0;
         core_rst_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         core_rst_r <= (next_state_s == ST_ARM);
         busy_r     <= (next_state_s == ST_ARM) || (next_state_s == ST_RUN) ||
                       (next_state_s == ST_STEP);
         done_r     <= (next_state_s == ST_DONE);

         if (next_state_s == ST_ARM) begin
            cycles_r <= {CYC_W{1'b0}};
         end else if (core_en_s && (cycles_r != CYC_MAX_C)) begin
            cycles_r <= cycles_r + {{(CYC_W-1){1'b0}}, 1'b1};
         end else begin
            cycles_r <= cycles_r;
         end

         if (next_state_s == ST_ARM) begin
            timeout_r <= 1'b0;
         end else if (set_timeout_s) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end

         if (next_state_s == ST_ARM) begin
            bp_hit_r <= 1'b0;
         end else if (set_bp_s) begin
            bp_hit_r <= 1'b1;
         end else begin
            bp_hit_r <= bp_hit_r;
         end
      end
   end

   // core_en_out is combinational so halt/breakpoint stops take effect at
   // once; an asynchronous reset forces IDLE and therefore drops it too.
   assign core_en_out  = core_en_s;
   assign core_rst_out = core_rst_r;
   assign busy_out     = busy_r;
   assign done_out     = done_r;
   assign timeout_out  = timeout_r;
   assign bp_hit_out   = bp_hit_r;
   assign cycles_out   = cycles_r;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Run-control sequencer sitting between the host interface and the processor core. It starts, single-steps and stops program execution by driving the core's run enable and pc reset. It counts executed cycles, enforces a watchdog limit, and optionally stops on a pc breakpoint. It reports busy/done/timeout/breakpoint status back to the host-facing logic.

## Interface

Parameters:
- PC_W, default 4: width of the program counter.
- CYC_W, default 8: width of the executed-cycle counter.
- WDT_LIMIT, default 255: watchdog limit in RUN cycles. 0 disables the watchdog. Must be ≤ 2^CYC_W-1.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start_in, in, 1: run request, level-sampled in IDLE.
- step_in, in, 1: single-step request, level-sampled in IDLE.
- halt_in, in, 1: abort request, honoured in RUN.
- pc_in, in, PC_W: current core pc.
- pc_en_in, in, 1: core pc-advance enable. 0 in RUN means the program has terminated.
- bp_addr_in, in, PC_W: breakpoint address.
- bp_valid_in, in, 1: breakpoint armed.
- core_en_out, out, 1: core run enable (combinational from state and inputs).
- core_rst_out, out, 1: core pc reset (high for exactly one cycle in ARM).
- busy_out, out, 1: high in ARM, RUN and STEP.
- done_out, out, 1: one-cycle pulse in DONE.
- timeout_out, out, 1: sticky, watchdog expired.
- bp_hit_out, out, 1: sticky, stopped on breakpoint.
- cycles_out, out, CYC_W: count of cycles with core_en_out high since last ARM.

## Operation

- States: IDLE, ARM, RUN, STEP, DONE. The state is a register; all other registered outputs reset to 0.
- IDLE:
  - core_en_out and core_rst_out are 0.
  - Priority is start_in, then step_in.
  - start_in goes to ARM. step_in goes to STEP.
  - halt_in is ignored.
- ARM:
  - core_rst_out is 1.
  - cycles_out, timeout_out and bp_hit_out clear to 0.
  - Next state is RUN unconditionally.
- RUN: core_en_out = 1 unless a stop condition holds this cycle. Stop conditions, in priority order:
  1. halt_in = 1: core_en_out = 0, go to DONE.
  2. Breakpoint match (BREAKPOINT_EN only): bp_valid_in & (pc_in == bp_addr_in) & (cycles_out != 0). core_en_out = 0, set bp_hit_out, go to DONE. The instruction at the breakpoint is not executed.
  3. pc_en_in = 0: core_en_out stays 1 and this cycle is counted. Go to DONE.
  4. WDT_LIMIT != 0 and cycles_out + 1 == WDT_LIMIT: this cycle is counted. Set timeout_out, go to DONE.
  - If no stop condition holds, stay in RUN.
- STEP:
  - core_en_out = 1 for exactly one cycle; cycles_out increments.
  - No pc reset and no flag clear, so stepping resumes from the current pc. This includes resuming past a breakpoint, because a match requires cycles_out != 0 only in RUN.
  - Next state is DONE.
- DONE: done_out = 1 and busy_out = 0. Next state is IDLE.
- cycles_out increments on every cycle where core_en_out = 1, saturating at 2^CYC_W-1.
- cycles_out, timeout_out and bp_hit_out hold their values until the next ARM.
- start_in and step_in are ignored outside IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. core_en_out drops asynchronously.

## Timing

- start_in high at edge k → ARM during cycle k+1 (core_rst_out=1, busy_out=1) → RUN from cycle k+2 (core_en_out=1).
- Termination seen (pc_en_in=0) in RUN cycle n → done_out=1 in cycle n+1 → IDLE in cycle n+2. start_in may be re-accepted at edge n+2.
- Run length L counted cycles → cycles_out = L, stable from the DONE cycle onward.
- Breakpoint and halt stops are zero-latency on core_en_out (same cycle). The state change is registered, so DONE follows one cycle later.
- step_in at edge k → STEP in cycle k+1 with exactly one core_en_out pulse → DONE in cycle k+2.
- Simultaneous halt_in and breakpoint match: halt wins and bp_hit_out stays 0.
- Simultaneous pc_en_in=0 and watchdog expiry: terminate path wins and timeout_out stays 0.

## Configuration

- Macro: EXEC_SEQUENCER_BREAKPOINT_EN.
- Defined: breakpoint compare logic is built as described above.
- Undefined: bp_addr_in and bp_valid_in are ignored, bp_hit_out is tied to 0, and breakpoint stop condition 2 never fires.

## Test plan

- Reset then start, with pc_en_in dropping on the 6th RUN cycle → core_rst_out pulses once; core_en_out is high for 6 cycles; cycles_out=6; done_out pulses once; timeout_out=0.
- WDT_LIMIT=10 with pc_en_in held at 1 → exactly 10 core_en_out cycles, cycles_out=10, timeout_out=1, done_out pulse.
- BREAKPOINT_EN defined, bp_addr_in=3 and bp_valid_in=1, pc sequence 0,1,2,3 → core_en_out=0 in the cycle pc_in=3; bp_hit_out=1; cycles_out=3. A following step_in gives one enable cycle and cycles_out=4.
- halt_in asserted in the 2nd RUN cycle, together with a breakpoint match → core_en_out=0 that cycle; bp_hit_out=0; cycles_out=1; DONE next cycle.
- rst_n pulled low during RUN → core_en_out drops immediately. After release, state is IDLE, all outputs 0, and start_in held high is ignored until reset deasserts.
- start_in and step_in asserted together in IDLE → ARM is taken (core_rst_out pulse). step_in held high during RUN has no effect.
